regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port general register file for the core, with NUM_RD read and NUM_WR write ports.
- Includes a per-register busy scoreboard, so issue logic can detect operands with an outstanding producer.
- Register 0 is hardwired to zero.
- Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W entries
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way
- rd_busy  out  NUM_RD  busy bit of the addressed register, per read port
- wr_en  in  NUM_WR  write enable, per write port
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- sb_set_en  in  1  mark a register busy (issue of an instruction with a destination)
- sb_set_addr  in  ADDR_W  register to mark busy
- busy_vec  out  2**ADDR_W  full scoreboard, for debug/stall logic

Interface: reset is named reset and is synchronous, active-high. The clock is named clk.

Behaviour:
- Storage: 2**ADDR_W x DATA_W registers, plus 2**ADDR_W busy flops.
- Reset (sampled high at a clk edge):
  - all registers load 0 and all busy bits load 0.
  - Reset overrides any concurrent write or scoreboard set.
  - Outputs after reset: rd_data = 0 for every address, rd_busy = 0, busy_vec = 0.
- Reads:
  - Combinational, zero latency: rd_data[k] = reg[rd_addr[k]].
  - Address 0 always returns 0 and rd_busy 0.
- Writes:
  - Take effect at the clk edge when wr_en[j]=1 and wr_addr[j] != 0.
  - Writes to address 0 are dropped.
  - Two or more ports writing the same address in one cycle: the highest-index port wins; lower ports are discarded for that address.
  - Writes to distinct addresses all commit in the same cycle.
- Scoreboard:
  - A committed write to addr A (wr_en[j]=1, A != 0) clears busy[A] at the edge.
  - sb_set_en=1 with sb_set_addr=A != 0 sets busy[A] at the edge.
  - Set and clear of the same address in one cycle: set wins, so busy stays 1 (a newer producer is outstanding).
  - sb_set_addr = 0 is ignored; busy[0] is constant 0.
  - rd_busy[k] = busy[rd_addr[k]], subject to the bypass rule below.
- No internal FSM beyond storage. All state changes occur only at the rising clk edge.
- Out-of-range address bits do not occur (depth is exactly a power of two).

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - Read ports forward same-cycle write data. If any wr_en[j]=1 with wr_addr[j]=rd_addr[k] != 0, rd_data[k] takes the wr_data of the highest-index such port.
  - rd_busy[k] reads 0 in that cycle, unless sb_set_en targets the same address, in which case it reads 1.
  - Gives write-then-read in the same cycle semantics.
- Not defined:
  - Reads return only the stored value; the new value is visible from the cycle after the edge.
  - rd_busy reflects only the stored busy bit.

Test Plan:
- Reset with random prior contents → every address reads 0x00000000, busy_vec == 0. Set busy[3] and assert reset in the same cycle → busy_vec == 0 after the edge.
- Write port0 addr 5 = 0xDEADBEEF → rd_addr0 = 5 reads 0xDEADBEEF the next cycle. Write addr 0 = 0x12345678 → addr 0 still reads 0, busy[0] stays 0.
- Same-cycle collision, port0 addr 7 = 0x11111111 and port1 addr 7 = 0x22222222 → addr 7 reads 0x22222222. Distinct addrs 8/9 written together → both committed.
- Scoreboard: sb_set addr 10 → rd_busy = 1 on a read of 10. Write addr 10 = 0xA5A5A5A5 → busy clears at that edge. Set and write addr 10 in the same cycle → busy remains 1 and data = 0xA5A5A5A5.
- With REGFILE_BYPASS_EN: write addr 4 = 0xCAFEF00D while reading addr 4 → rd_data = 0xCAFEF00D in the same cycle. Without the macro: old value in that cycle, new value the next cycle.
- NUM_RD=4, NUM_WR=3, DATA_W=64 build → all four read ports independently return 64-bit values written through port 2, e.g. 0x0123456789ABCDEF.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register busy scoreboard, x0 hardwired to zero.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data/busy onto the read ports.
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     sb_set_en,
  input  logic [ADDR_W-1:0]        sb_set_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs   [DEPTH];
  logic [DATA_W-1:0] wr_val [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  set_hit;

  // Per-entry write select; later ports override earlier ones on a collision.
  always_comb begin
    wr_hit  = '0;
    set_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_val[i] = regs[i];
      for (int j = 0; j < NUM_WR; j++) begin
        if (i != 0 && wr_en[j] &&
            wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
          wr_hit[i] = 1'b1;
          wr_val[i] = wr_data[j*DATA_W +: DATA_W];
        end
      end
      set_hit[i] = (i != 0) && sb_set_en &&
                   (sb_set_addr == ADDR_W'(i));
    end
  end

  // Storage and scoreboard update; a new producer (set) beats a writeback (clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= wr_val[i];
        busy[i] <= set_hit[i] | (busy[i] & ~wr_hit[i]);
      end
    end
  end

  assign busy_vec = busy;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;
`ifdef REGFILE_BYPASS_EN
    logic              hit;
`endif

    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    // Read mux, optionally forwarding the winning same-cycle write.
    always_comb begin
      d = regs[a];
      b = busy[a];
`ifdef REGFILE_BYPASS_EN
      hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == a) begin
          hit = 1'b1;
          d   = wr_data[j*DATA_W +: DATA_W];
        end
      end
      if (hit) begin
        b = sb_set_en && (sb_set_addr == a);
      end
`endif
      if (a == '0) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_busy[k] = b;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: default build plus a 4R/3W 64-bit build.
// Expectations are queued per cycle and checked by a monitor at the falling edge.
module tb_regfile_mp_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default build
  logic [9:0]  rd_addr_a;
  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [1:0]  wr_en_a;
  logic [9:0]  wr_addr_a;
  logic [63:0] wr_data_a;
  logic        sb_en_a;
  logic [4:0]  sb_addr_a;
  logic [31:0] busy_vec_a;

  // Wide build
  logic [19:0]  rd_addr_b;
  logic [255:0] rd_data_b;
  logic [3:0]   rd_busy_b;
  logic [2:0]   wr_en_b;
  logic [14:0]  wr_addr_b;
  logic [191:0] wr_data_b;
  logic         sb_en_b;
  logic [4:0]   sb_addr_b;
  logic [31:0]  busy_vec_b;

  regfile_mp_sb dut_a (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .sb_set_en(sb_en_a), .sb_set_addr(sb_addr_a),
    .busy_vec(busy_vec_a)
  );

  regfile_mp_sb #(
    .DATA_W(64), .ADDR_W(5), .NUM_RD(4), .NUM_WR(3)
  ) dut_b (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .sb_set_en(sb_en_b), .sb_set_addr(sb_addr_b),
    .busy_vec(busy_vec_b)
  );

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;
    int          port;
    logic [63:0] data;
    logic        busy;
    logic [31:0] vec;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle();
    reset     = 1'b0;
    rd_addr_a = '0; wr_en_a = '0; wr_addr_a = '0; wr_data_a = '0;
    sb_en_a   = 1'b0; sb_addr_a = '0;
    rd_addr_b = '0; wr_en_b = '0; wr_addr_b = '0; wr_data_b = '0;
    sb_en_b   = 1'b0; sb_addr_b = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wa(input int p, input int a, input logic [31:0] d);
    wr_en_a[p] = 1'b1;
    wr_addr_a[p*5 +: 5] = 5'(a);
    wr_data_a[p*32 +: 32] = d;
  endtask

  task automatic ra(input int p, input int a);
    rd_addr_a[p*5 +: 5] = 5'(a);
  endtask

  task automatic sb(input int a);
    sb_en_a = 1'b1;
    sb_addr_a = 5'(a);
  endtask

  task automatic wb(input int p, input int a, input logic [63:0] d);
    wr_en_b[p] = 1'b1;
    wr_addr_b[p*5 +: 5] = 5'(a);
    wr_data_b[p*64 +: 64] = d;
  endtask

  task automatic rb(input int p, input int a);
    rd_addr_b[p*5 +: 5] = 5'(a);
  endtask

  task automatic ea(input int p, input logic [31:0] d,
                    input logic b, input string n);
    exp_t e;
    e.cyc = cyc; e.dut = 0; e.kind = 0; e.port = p;
    e.data = {32'h0, d}; e.busy = b; e.vec = '0; e.name = n;
    q.push_back(e);
  endtask

  task automatic ev(input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = cyc; e.dut = 0; e.kind = 1; e.port = 0;
    e.data = '0; e.busy = 1'b0; e.vec = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic eb(input int p, input logic [63:0] d, input string n);
    exp_t e;
    e.cyc = cyc; e.dut = 1; e.kind = 0; e.port = p;
    e.data = d; e.busy = 1'b0; e.vec = '0; e.name = n;
    q.push_back(e);
  endtask

  // Monitor: checks everything queued for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      logic [63:0] ad;
      logic        ab;
      logic [31:0] av;
      e = q.pop_front();
      if (e.kind == 1) begin
        av = busy_vec_a;
        n_checks++;
        if (av !== e.vec) begin
          n_fail++;
          $display("FAIL %s busy_vec got %h want %h", e.name, av, e.vec);
        end
      end else begin
        if (e.dut == 0) begin
          ad = {32'h0, rd_data_a[e.port*32 +: 32]};
          ab = rd_busy_a[e.port];
        end else begin
          ad = rd_data_b[e.port*64 +: 64];
          ab = rd_busy_b[e.port];
        end
        n_checks++;
        if (ad !== e.data) begin
          n_fail++;
          $display("FAIL %s data got %h want %h", e.name, ad, e.data);
        end
        n_checks++;
        if (ab !== e.busy) begin
          n_fail++;
          $display("FAIL %s busy got %b want %b", e.name, ab, e.busy);
        end
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    step(); reset = 1'b1;
    step(); reset = 1'b1;

    // Dirty the state, then reset over a concurrent write and set
    step(); wa(0, 1, $urandom); wa(1, 2, $urandom); sb(3);
    step(); wa(0, 6, $urandom); sb(3); reset = 1'b1;
    step(); ra(0, 1); ra(1, 2);
    ea(0, 32'h0, 1'b0, "rst_r1"); ea(1, 32'h0, 1'b0, "rst_r2");
    ev(32'h0, "rst_vec");
    step(); ra(0, 3); ra(1, 6);
    ea(0, 32'h0, 1'b0, "rst_r3"); ea(1, 32'h0, 1'b0, "rst_r6");

    // Basic write, write to x0
    step(); wa(0, 5, 32'hDEADBEEF); ra(0, 5);
    ea(0, BYP ? 32'hDEADBEEF : 32'h0, 1'b0, "wr5_same");
    step(); ra(0, 5); wa(1, 0, 32'h12345678); ra(1, 0);
    ea(0, 32'hDEADBEEF, 1'b0, "wr5_next");
    ea(1, 32'h0, 1'b0, "x0_same");
    step(); ra(1, 0);
    ea(1, 32'h0, 1'b0, "x0_next"); ev(32'h0, "x0_busy");

    // Collision and distinct writes
    step(); wa(0, 7, 32'h11111111); wa(1, 7, 32'h22222222); ra(0, 7);
    ea(0, BYP ? 32'h22222222 : 32'h0, 1'b0, "coll_same");
    step(); ra(0, 7); wa(0, 8, 32'h88888888); wa(1, 9, 32'h99999999);
    ea(0, 32'h22222222, 1'b0, "coll_next");
    step(); ra(0, 8); ra(1, 9);
    ea(0, 32'h88888888, 1'b0, "dist8"); ea(1, 32'h99999999, 1'b0, "dist9");

    // Scoreboard
    step(); sb(10); ra(0, 10);
    ea(0, 32'h0, 1'b0, "sb_set_same");
    step(); ra(0, 10);
    ea(0, 32'h0, 1'b1, "sb_busy"); ev(32'h0000_0400, "sb_vec");
    step(); wa(0, 10, 32'hA5A5A5A5); ra(0, 10);
    ea(0, BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 1'b0 : 1'b1, "sb_clr_same");
    step(); ra(0, 10);
    ea(0, 32'hA5A5A5A5, 1'b0, "sb_clr"); ev(32'h0, "sb_clr_vec");
    step(); sb(10); wa(1, 10, 32'hA5A5A5A5); ra(0, 10);
    ea(0, 32'hA5A5A5A5, BYP ? 1'b1 : 1'b0, "sb_both_same");
    step(); ra(0, 10);
    ea(0, 32'hA5A5A5A5, 1'b1, "sb_both"); ev(32'h0000_0400, "sb_both_vec");
    step(); sb(0); ra(0, 0);
    ea(0, 32'h0, 1'b0, "sb_x0_same");
    step(); ev(32'h0000_0400, "sb_x0_vec");

    // Write-then-read in the same cycle
    step(); wa(0, 4, 32'hCAFEF00D); ra(1, 4);
    ea(1, BYP ? 32'hCAFEF00D : 32'h0, 1'b0, "byp_same");
    step(); ra(1, 4);
    ea(1, 32'hCAFEF00D, 1'b0, "byp_next");
    step(); wa(0, 11, 32'h1); wa(1, 11, 32'h2); ra(0, 11);
    ea(0, BYP ? 32'h2 : 32'h0, 1'b0, "byp_prio");

    // Wide build
    step(); wb(2, 12, 64'h0123456789ABCDEF);
    step(); wb(2, 13, 64'hFEDCBA9876543210);
    wb(0, 14, 64'h5555555555555555); wb(1, 14, 64'hAAAAAAAAAAAAAAAA);
    step(); rb(0, 12); rb(1, 13); rb(2, 14); rb(3, 12);
    eb(0, 64'h0123456789ABCDEF, "b_p0");
    eb(1, 64'hFEDCBA9876543210, "b_p1");
    eb(2, 64'hAAAAAAAAAAAAAAAA, "b_p2");
    eb(3, 64'h0123456789ABCDEF, "b_p3");

    step(); step(); step();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s unchecked got none want check", e.name);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
